// File: rtl/buzzer_seq.sv
// buzzer_seq: note FIFO plus sequencer that turns queued notes into
// one-cycle buzzer commands.
//
// Parameters
//   TICK_DIV  clock cycles per duration tick
//   DEPTH     note FIFO entries (power of two, >= 2)
//
// Ports
//   clk      sole clock, rising edge
//   rst      synchronous active-low reset
//   wr       push strobe for wr_data
//   wr_data  [5:0] tone code (0 = rest), [15:6] duration in ticks
//   abort    flush FIFO and silence (priority over wr and the sequencer)
//   cmd      [23:16] opcode (0 NOP, 1 SET, 2 STOP), [5:0] tone, rest 0
//   start    one-cycle strobe qualifying a non-NOP cmd
//   full     FIFO holds DEPTH entries (registered)
//   empty    FIFO holds no entries (registered)
//   busy     sequencer active
//   ovf      one-cycle pulse on a dropped write
//
// Build option
//   BUZZER_SEQ_GAP_EN  adds a one-tick STOP gap after every note instead of
//                      back-to-back playback with a final STOP.
//
// Outputs are registered from the state being left, so the command of a
// state appears on the edge that ends its cycle: a write into an idle,
// empty FIFO yields start two edges after the write edge.
module buzzer_seq #(
  parameter int TICK_DIV = 50000,
  parameter int DEPTH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [15:0] wr_data,
  input  logic        abort,
  output logic [23:0] cmd,
  output logic        start,
  output logic        full,
  output logic        empty,
  output logic        busy,
  output logic        ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [SW-1:0] PS_LAST   = SW'(TICK_DIV - 1);
  localparam logic [PW-1:0] FIFO_FULL = PW'(DEPTH);
  localparam logic [23:0]   CMD_STOP  = 24'h020000;

`ifdef BUZZER_SEQ_GAP_EN
  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, STOP_OUT} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, PLAY, STOP_OUT} state_t;
`endif

  state_t state;

  // ---------------------------------------------------------------- FIFO
  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic          pop, push;
  logic [15:0]   head;
  logic [5:0]    head_tone;
  logic [9:0]    head_dur;

  assign head      = mem[rd_ptr[AW-1:0]];
  assign head_tone = head[5:0];
  assign head_dur  = head[15:6];

  always_comb begin
    pop  = (state == LOAD) && !abort;
    // A full FIFO still accepts a write when the same edge pops.
    push = wr && !abort && (!full || pop);
    if (abort) begin
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = wr_ptr;
    end else begin
      wr_ptr_nxt = wr_ptr + PW'(push);
      rd_ptr_nxt = rd_ptr + PW'(pop);
    end
    level_nxt = wr_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      full   <= (level_nxt == FIFO_FULL);
      empty  <= (level_nxt == '0);
      // Writes coinciding with abort are dropped silently.
      ovf    <= wr && !abort && !push;
    end
  end

  // ----------------------------------------------------------- sequencer
  logic [SW-1:0] presc;
  logic [9:0]    dur_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      presc   <= '0;
      dur_cnt <= '0;
      cmd     <= '0;
      start   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      cmd   <= '0;
      start <= 1'b0;
      if (abort) begin
        presc   <= '0;
        dur_cnt <= '0;
        if (busy) begin
          state <= STOP_OUT;
          busy  <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
            if (!empty) state <= LOAD;
          end
          LOAD: begin
            busy    <= 1'b1;
            start   <= 1'b1;
            cmd     <= (head_tone != '0) ? {8'd1, 10'd0, head_tone} : CMD_STOP;
            presc   <= '0;
            dur_cnt <= (head_dur == '0) ? 10'd1 : head_dur;
            state   <= PLAY;
          end
          PLAY: begin
            busy <= 1'b1;
            if (presc == PS_LAST) begin
              presc <= '0;
              if (dur_cnt <= 10'd1) begin
`ifdef BUZZER_SEQ_GAP_EN
                state <= GAP;
`else
                state <= empty ? STOP_OUT : LOAD;
`endif
              end else begin
                dur_cnt <= dur_cnt - 10'd1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
`ifdef BUZZER_SEQ_GAP_EN
          GAP: begin
            busy <= 1'b1;
            // presc is 0 only in the first gap cycle.
            if (presc == '0) begin
              start <= 1'b1;
              cmd   <= CMD_STOP;
            end
            if (presc == PS_LAST) begin
              presc <= '0;
              state <= empty ? IDLE : LOAD;
            end else begin
              presc <= presc + 1'b1;
            end
          end
`endif
          STOP_OUT: begin
            busy  <= 1'b1;
            start <= 1'b1;
            cmd   <= CMD_STOP;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buzzer_seq.sv
// Self-checking bench for buzzer_seq (TICK_DIV = 4, DEPTH = 4).
// A queue-based reference model predicts every output after every edge;
// directed sections add fixed-timing expectations for the key scenarios.
module tb_buzzer_seq;

  localparam int TD = 4;
  localparam int DP = 4;
  localparam logic [23:0] STOP_C = 24'h020000;

  logic        clk = 1'b0;
  logic        rst, wr, abort;
  logic [15:0] wr_data;
  logic [23:0] cmd;
  logic        start, full, empty, busy, ovf;

  int total = 0;
  int bad   = 0;

  buzzer_seq #(.TICK_DIV(TD), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .wr(wr), .wr_data(wr_data), .abort(abort),
    .cmd(cmd), .start(start), .full(full), .empty(empty), .busy(busy),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------ reference model
  localparam int M_IDLE = 0, M_LOAD = 1, M_PLAY = 2, M_GAP = 3, M_STOP = 4;
  logic [15:0] q[$];
  int          ph   = M_IDLE;
  int          left = 0;
  logic [23:0] e_cmd = '0;
  logic        e_start = 0, e_busy = 0, e_full = 0, e_empty = 1, e_ovf = 0;

  task automatic model_edge(input logic w, input logic [15:0] d,
                            input logic a, input logic r);
    logic        empty_p, pop, acc;
    logic [15:0] note;
    int          dd;
    e_cmd = '0; e_start = 0; e_ovf = 0;
    if (!r) begin
      q.delete(); ph = M_IDLE; left = 0; e_busy = 0;
    end else if (a) begin
      q.delete();
      ph = e_busy ? M_STOP : M_IDLE;
    end else begin
      empty_p = (q.size() == 0);
      pop     = (ph == M_LOAD);
      acc     = w && (q.size() < DP || pop);
      e_ovf   = w && !acc;
      case (ph)
        M_IDLE: begin
          e_busy = 0;
          if (!empty_p) ph = M_LOAD;
        end
        M_LOAD: begin
          e_busy = 1;
          note = (q.size() > 0) ? q.pop_front() : 16'h0;
          dd   = int'(note[15:6]);
          e_start = 1;
          e_cmd = (note[5:0] == 0) ? STOP_C : {8'd1, 10'd0, note[5:0]};
          left = ((dd == 0) ? 1 : dd) * TD;
          ph = M_PLAY;
        end
        M_PLAY: begin
          e_busy = 1;
          left--;
          if (left == 0) begin
`ifdef BUZZER_SEQ_GAP_EN
            ph = M_GAP; left = TD;
`else
            ph = empty_p ? M_STOP : M_LOAD;
`endif
          end
        end
        M_GAP: begin
          e_busy = 1;
          if (left == TD) begin e_start = 1; e_cmd = STOP_C; end
          left--;
          if (left == 0) ph = empty_p ? M_IDLE : M_LOAD;
        end
        default: begin
          e_busy = 1; e_start = 1; e_cmd = STOP_C; ph = M_IDLE;
        end
      endcase
      if (acc) q.push_back(d);
    end
    e_full  = (q.size() == DP);
    e_empty = (q.size() == 0);
  endtask

  // -------------------------------------------------------------- helpers
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic w, input logic [15:0] d,
                      input logic a, input logic r);
    wr = w; wr_data = d; abort = a; rst = r;
    @(posedge clk);
    model_edge(w, d, a, r);
    #1;
    check("model", {3'b0, cmd, start, busy, full, empty, ovf},
                   {3'b0, e_cmd, e_start, e_busy, e_full, e_empty, e_ovf});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  // Advance n edges; the last must carry a start with cmd = exp.
  task automatic adv(input int n, input logic [23:0] exp, input string tag);
    int s = 0;
    for (int i = 0; i < n - 1; i++) begin
      idle(1);
      s += int'(start);
    end
    if (n > 1) check({tag, "_quiet"}, s, 0);
    idle(1);
    check(tag, {7'b0, start, cmd}, {7'b0, 1'b1, exp});
  endtask

  task automatic do_reset();
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [15:0] note_of(input int d, input int t);
    return {10'(d), 6'(t)};
  endfunction

  // ------------------------------------------------------------- stimulus
  initial begin
    int          s, n;
    logic [23:0] sets[$];
    logic        rw, ra, rr;
    logic [15:0] rd;

    wr = 0; wr_data = '0; abort = 0; rst = 0;
    do_reset();
    check("rst_vals", {3'b0, cmd, start, busy, full, empty, ovf},
                      {3'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    idle(2);

    // Single note D=3 tone 5
    step(1'b1, note_of(3, 5), 1'b0, 1'b1);
    adv(2, 24'h010005, "single_set");
    adv(13, STOP_C, "single_stop");
`ifdef BUZZER_SEQ_GAP_EN
    idle(4);
`else
    idle(1);
`endif
    check("single_busy_off", {31'b0, busy}, 32'd0);
    idle(3);

    // Two notes: D=2 tone 7, then D=1 rest
    step(1'b1, note_of(2, 7), 1'b0, 1'b1);
    step(1'b1, note_of(1, 0), 1'b0, 1'b1);
    adv(1, 24'h010007, "b2b_set");
`ifdef BUZZER_SEQ_GAP_EN
    adv(9, STOP_C, "gap_stop1");
    adv(4, STOP_C, "gap_rest_load");
    adv(5, STOP_C, "gap_stop2");
    s = 0;
    for (int i = 0; i < 4; i++) begin idle(1); s += int'(start); end
    check("gap_no_stop_out", s, 0);
    check("gap_busy_off", {31'b0, busy}, 32'd0);
`else
    adv(9, STOP_C, "b2b_rest");
    adv(5, STOP_C, "b2b_stop_out");
    idle(1);
    check("b2b_busy_off", {31'b0, busy}, 32'd0);
`endif
    idle(3);

    // Overflow while a long note plays (no pops during the writes)
    do_reset();
    step(1'b1, note_of(20, 1), 1'b0, 1'b1);
    idle(2);
    for (int i = 0; i < 4; i++) step(1'b1, note_of(1, 11 + i), 1'b0, 1'b1);
    check("ovf_full4", {30'b0, full, ovf}, {30'b0, 1'b1, 1'b0});
    step(1'b1, note_of(1, 15), 1'b0, 1'b1);
    check("ovf_pulse", {30'b0, full, ovf}, {30'b0, 1'b1, 1'b1});
    idle(1);
    check("ovf_once", {31'b0, ovf}, 32'd0);
    for (int i = 0; i < 150; i++) begin
      idle(1);
      if (start && cmd[23:16] == 8'd1) sets.push_back(cmd);
    end
    n = sets.size();
    check("ovf_nsets", n, 4);
    for (int i = 0; i < 4; i++)
      check("ovf_order", (i < n) ? {8'b0, sets[i]} : 32'hFFFFFFFF,
            {8'b0, 8'd1, 10'd0, 6'(11 + i)});

    // Abort mid-PLAY with two notes queued
    do_reset();
    step(1'b1, note_of(20, 2), 1'b0, 1'b1);
    step(1'b1, note_of(1, 3), 1'b0, 1'b1);
    step(1'b1, note_of(1, 4), 1'b0, 1'b1);
    idle(8);
    step(1'b0, 16'h0, 1'b1, 1'b1);
    check("abort_flush", {30'b0, empty, start}, {30'b0, 1'b1, 1'b0});
    idle(1);
    check("abort_stop", {7'b0, start, cmd}, {7'b0, 1'b1, STOP_C});
    idle(1);
    check("abort_idle", {30'b0, busy, empty}, {30'b0, 1'b0, 1'b1});
    s = 0;
    for (int i = 0; i < 12; i++) begin idle(1); s += int'(start); end
    check("abort_silent", s, 0);
    step(1'b1, note_of(2, 9), 1'b1, 1'b1);
    check("abort_wr", {30'b0, empty, ovf}, {30'b0, 1'b1, 1'b0});
    s = 0;
    for (int i = 0; i < 6; i++) begin idle(1); s += int'(start); end
    check("abort_wr_silent", s, 0);

    // Reset mid-PLAY
    step(1'b1, note_of(5, 9), 1'b0, 1'b1);
    adv(2, 24'h010009, "rst_mid_set");
    idle(3);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    check("rst_mid_vals", {3'b0, cmd, start, busy, full, empty, ovf},
                          {3'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    s = 0;
    for (int i = 0; i < 25; i++) begin idle(1); s += int'(start); end
    check("rst_mid_no_stop", s, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      rw = ($urandom_range(0, 9) < 3);
      rd = {10'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
      ra = ($urandom_range(0, 99) < 2);
      rr = ($urandom_range(0, 199) != 0);
      step(rw, rd, ra, rr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
